exception_ctrl: RTL

// - MEM-stage exception arbiter; the driving end of the CP0 exception interface.
// - Merges per-instruction exception flags with pending interrupts and selects one cause by priority.
// - Drives excepttype/current_inst_addr/is_in_delayslot/bad_addr into the CP0 register block.
// - Issues a one-cycle pipeline flush plus the redirect PC (exception vector, or EPC for ERET).

---
 rtl/exception_ctrl_pkg.sv | 26 ++
 rtl/exception_ctrl_prio_enc.sv | 18 +
 rtl/exception_ctrl.sv | 67 ++++++
 3 files changed

// File: rtl/exception_ctrl_pkg.sv
// exception_ctrl_pkg: exception codes, CP0 register numbers and flag-bit indices shared by the exception arbiter
package exception_ctrl_pkg;
  typedef enum logic {IDLE, FLUSH} state_t;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
  localparam logic [31:0] EXC_NONE = 32'h0;
  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_ADEL = 32'h4;
  localparam logic [31:0] EXC_ADES = 32'h5;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_BRK  = 32'h9;
  localparam logic [31:0] EXC_RI   = 32'ha;
  localparam logic [31:0] EXC_OV   = 32'hc;
  localparam logic [31:0] EXC_TRAP = 32'hd;
  localparam logic [31:0] EXC_ERET = 32'he;
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;
  localparam int F_ADEL = 0;
  localparam int F_ADES = 1;
  localparam int F_SYS  = 2;
  localparam int F_BRK  = 3;
  localparam int F_RI   = 4;
  localparam int F_OV   = 5;
  localparam int F_TRAP = 6;
  localparam int F_ERET = 7;
endpackage

// File: rtl/exception_ctrl_prio_enc.sv
// exc_prio_enc: picks the single highest-priority exception code from the flags and interrupt
module exc_prio_enc
  import exception_ctrl_pkg::*;
(
  input  logic [7:0]  flags,
  input  logic        irq,
  output logic [31:0] code
);
  assign code = irq            ? EXC_INT  :
                flags[F_ADEL]  ? EXC_ADEL :
                flags[F_ADES]  ? EXC_ADES :
                flags[F_SYS]   ? EXC_SYS  :
                flags[F_BRK]   ? EXC_BRK  :
                flags[F_RI]    ? EXC_RI   :
                flags[F_OV]    ? EXC_OV   :
                flags[F_TRAP]  ? EXC_TRAP :
                flags[F_ERET]  ? EXC_ERET : EXC_NONE;
endmodule

// File: rtl/exception_ctrl.sv
// exception_ctrl: MEM-stage exception arbiter driving CP0 plus the one-cycle flush and redirect PC
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic        stall_i,
  input  logic [31:0] inst_addr_i,
  input  logic        in_delayslot_i,
  input  logic [7:0]  exc_flags_i,
  input  logic [31:0] bad_addr_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_addr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] epc_addr_o,
  output logic        delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] exc_count_o
);
  state_t state, state_n;
  logic [31:0] status, cause, epc, code;
  logic wb_status, wb_cause, wb_epc, int_cond, int_pend_q, take, unused_bits;
  // an mtc0 still in WB must be seen as if CP0 already held it
  assign wb_status = wb_cp0_we_i && wb_cp0_addr_i == CP0_STATUS;
  assign wb_cause = wb_cp0_we_i && wb_cp0_addr_i == CP0_CAUSE;
  assign wb_epc = wb_cp0_we_i && wb_cp0_addr_i == CP0_EPC;
  assign status = wb_status ? wb_cp0_data_i : cp0_status_i;
  assign epc = wb_epc ? wb_cp0_data_i : cp0_epc_i;
  assign cause = wb_cause ? {cp0_cause_i[31:24], wb_cp0_data_i[23:22], cp0_cause_i[21:10],
                             wb_cp0_data_i[9:8], cp0_cause_i[7:0]} : cp0_cause_i;
  assign int_cond = |(cause[15:8] & status[15:8]) && status[0] && !status[1];
  assign unused_bits = ^{status[31:16], status[7:2], cause[31:16], cause[7:0]};
  exc_prio_enc u_enc (
    .flags(exc_flags_i),
    .irq  (int_cond || int_pend_q),
    .code (code)
  );
  assign take = !rst && state == IDLE && mem_valid_i && !stall_i && code != EXC_NONE;
  assign epc_addr_o = inst_addr_i;
  assign delayslot_o = in_delayslot_i;
  assign bad_addr_o = bad_addr_i;
  always_comb begin
    state_n = take ? FLUSH : IDLE;
    excepttype_o = take ? code : EXC_NONE;
    flush_o = take;
    new_pc_o = !take ? '0 : code == EXC_ERET ? epc : EXC_VECTOR;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      int_pend_q <= 1'b0;
      exc_count_o <= '0;
    end else begin
      state <= state_n;
      int_pend_q <= int_cond && !(take && code == EXC_INT);
      exc_count_o <= exc_count_o + 32'(take);
    end
endmodule
